// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions used by the fetch stage and its skid buffer.
//   NOP_INSTR_DEFAULT : instruction word shown in IF/ID when it holds no instruction
//   WORD_BYTES        : byte stride between consecutive instruction words
//   if_id_entry_t     : {valid, pc, instr}, used by the IF/ID register and the skid entry
//   fetch_state_e     : RUN (skid empty) / PARKED (skid full)
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES        = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_entry_t;

  typedef enum logic {
    RUN    = 1'b0,
    PARKED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry hold register that parks the memory response already in flight
// when decode stalls.
//   clk, rst_n : clock, async active-low reset
//   flush_i    : drop the entry (highest priority)
//   load_i     : capture entry_i
//   drain_i    : entry consumed by IF/ID, clear it
//   entry_i    : entry to capture
//   entry_o    : current entry (valid bit says whether it is occupied)
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic         drain_i,
  input  if_id_entry_t entry_i,
  output if_id_entry_t entry_o
);

  if_id_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (flush_i || drain_i) begin
      entry_d.valid = 1'b0;
    end else if (load_i) begin
      entry_d = entry_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: sequences fetch addresses into a one-cycle-latency
// instruction memory and fills the IF/ID register, honouring decode stall and
// downstream redirect. A one-entry skid buffer catches the response in flight
// when a stall arrives.
//   clk, rst_n      : clock, async active-low reset
//   stall_i         : decode hazard, IF/ID must hold
//   redirect_i      : taken branch/jump, redirect_pc_i is the target
//   imem_en_o       : memory read request this cycle
//   imem_addr_o     : word-aligned read address
//   imem_rdata_i    : data for last cycle's request
//   if_id_*_o       : IF/ID register contents (pc4 = pc + 4)
//
// state  | meaning
// RUN    | skid entry empty, responses go straight to IF/ID
// PARKED | skid entry holds a fetched instruction waiting for the stall to clear
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_en_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o
);

  logic [31:0]  next_pc_q, next_pc_d;
  logic         inflight_q;
  logic [31:0]  inflight_pc_q;
  if_id_entry_t if_id_q, if_id_d;
  if_id_entry_t hold_q, resp;
  fetch_state_e state;
  logic         issue;
  logic [31:0]  req_addr;
  logic         hold_load, hold_drain, hold_flush;

  assign state = hold_q.valid ? PARKED : RUN;
  assign resp  = '{valid: 1'b1, pc: inflight_pc_q, instr: imem_rdata_i};

  always_comb begin
    issue      = 1'b0;
    req_addr   = next_pc_q;
    next_pc_d  = next_pc_q;
    if_id_d    = if_id_q;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    hold_flush = 1'b0;

    // While stalled, only fetch if nothing is parked or on its way; this is
    // what keeps the single skid entry from ever overflowing.
    if (redirect_i) begin
      issue    = 1'b1;
      req_addr = {redirect_pc_i[31:2], 2'b00};
    end else begin
      issue = !stall_i || (state == RUN && !inflight_q);
    end
    if (issue) begin
      next_pc_d = req_addr + WORD_BYTES;
    end

    if (redirect_i) begin
      hold_flush    = 1'b1;
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end else if (stall_i) begin
      hold_load = inflight_q;
    end else if (state == PARKED) begin
      if_id_d    = hold_q;
      hold_drain = 1'b1;
    end else if (inflight_q) begin
      if_id_d = resp;
    end else begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_pc_q     <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      if_id_q       <= '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR};
    end else begin
      next_pc_q     <= next_pc_d;
      inflight_q    <= issue;
      inflight_pc_q <= req_addr;
      if_id_q       <= if_id_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (hold_flush),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .entry_i (resp),
    .entry_o (hold_q)
  );

  // Gate with rst_n so no request leaks out while reset is held.
  assign imem_en_o     = issue & rst_n;
  assign imem_addr_o   = rst_n ? req_addr : RESET_PC;
  assign if_id_valid_o = if_id_q.valid;
  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_pc4_o   = if_id_q.pc + WORD_BYTES;
  assign if_id_instr_o = if_id_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o, if_id_pc4_o, if_id_instr_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_en_o     (imem_en_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_instr_o (if_id_instr_o)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word at byte address 4n holds n.
  always @(posedge clk) begin
    if (imem_en_o) imem_rdata_i <= imem_addr_o >> 2;
  end

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic en,
                              logic [31:0] addr, logic vld, logic [31:0] pc,
                              logic [31:0] instr);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rpc; v.en = en; v.addr = addr;
    v.valid = vld; v.pc = pc; v.instr = instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " en"},    {31'b0, imem_en_o}, 32'd0);
    chk({tag, " addr"},  imem_addr_o, 32'h0);
    chk({tag, " valid"}, {31'b0, if_id_valid_o}, 32'd0);
    chk({tag, " pc"},    if_id_pc_o, 32'h0);
    chk({tag, " pc4"},   if_id_pc4_o, 32'h4);
    chk({tag, " instr"}, if_id_instr_o, NOP);
  endtask

  // Called at a negedge: drive, check request, take the edge, check IF/ID.
  task automatic step(input vec_t v, input string tag);
    stall_i = v.stall; redirect_i = v.redir; redirect_pc_i = v.rpc;
    #1;
    chk({tag, " en"},   {31'b0, imem_en_o}, {31'b0, v.en});
    chk({tag, " addr"}, imem_addr_o, v.addr);
    @(posedge clk); #1;
    chk({tag, " valid"}, {31'b0, if_id_valid_o}, {31'b0, v.valid});
    chk({tag, " instr"}, if_id_instr_o, v.instr);
    if (v.valid) begin
      chk({tag, " pc"},  if_id_pc_o, v.pc);
      chk({tag, " pc4"}, if_id_pc4_o, v.pc + 32'd4);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //                st rd rpc           en addr          vld pc            instr
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        NOP));          // c0 first issue
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h0));        // c1
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h1));        // c2
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hC,        1, 32'h8,        32'h2));        // c3
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h10,       1, 32'h8,        32'h2));        // c4 stall, park 12
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h10,       1, 32'h8,        32'h2));        // c5
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h10,       1, 32'h8,        32'h2));        // c6
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h10,       1, 32'hC,        32'h3));        // c7 drain
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h14,       1, 32'h10,       32'h4));        // c8
    vecs.push_back(mk(1, 1, 32'h103,      1, 32'h100,      0, 32'h0,        NOP));          // c9 redirect in stall
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h104,      1, 32'h100,      32'h40));       // c10
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h108,      1, 32'h100,      32'h40));       // c11 park 0x104
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h108,      1, 32'h100,      32'h40));       // c12
    vecs.push_back(mk(1, 1, 32'h200,      1, 32'h200,      0, 32'h0,        NOP));          // c13 redirect while parked
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h204,      0, 32'h0,        NOP));          // c14 still stalled
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h204,      1, 32'h200,      32'h80));       // c15
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h208,      1, 32'h204,      32'h81));       // c16 never 0x104
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0,      NOP));          // c17
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0,        1, 32'hFFFF_FFFC, 32'h3FFF_FFFF)); // c18 wrap
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h0));        // c19
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h8,        1, 32'h0,        32'h0));        // c20 park 4

    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // Reset asserted mid-cycle while PARKED: outputs clear without a clock edge.
    stall_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 0, 32'h0, 1, 32'h0, 0, 32'h0, NOP),   "rst_r0");
    step(mk(0, 0, 32'h0, 1, 32'h4, 1, 32'h0, 32'h0), "rst_r1");
    step(mk(0, 0, 32'h0, 1, 32'h8, 1, 32'h4, 32'h1), "rst_r2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the fetch address sequencing and issues requests to a synchronous instruction memory with one-cycle read latency. It presents fetched instructions to decode through the IF/ID pipeline register, honouring the decode-side hazard stall and the branch/jump redirect from later stages. A one-entry skid buffer absorbs the response that is already in flight when a stall arrives, so that no fetch is lost and none is issued twice.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0000: value of `if_id_instr` when invalid or in reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall_i` input 1: hazard detected in decode; the IF/ID register must hold.
- `redirect_i` input 1: a taken branch or jump has resolved downstream.
- `redirect_pc_i` input 32: target address for a redirect; bits [1:0] are ignored.
- `imem_en_o` output 1: instruction memory read request this cycle.
- `imem_addr_o` output 32: word-aligned read address, valid when `imem_en_o` is high.
- `imem_rdata_i` input 32: read data for the request made in the previous cycle.
- `if_id_valid_o` output 1: the IF/ID register holds a real instruction.
- `if_id_pc_o` output 32: PC of the instruction in IF/ID.
- `if_id_pc4_o` output 32: `if_id_pc_o` + 4, modulo 2^32.
- `if_id_instr_o` output 32: instruction word in IF/ID.

## Operation
Internal state:
- `next_pc`: address of the next request.
- `inflight`: a request was issued last cycle; also holds that request's PC and a kill bit.
- `hold`: skid entry with valid bit, PC and instruction.

Derived control states:
- RUN: `hold` empty.
- PARKED: `hold` full.

Request issue:
- With `redirect_i` high: `imem_en_o` = 1 and `imem_addr_o` = {`redirect_pc_i`[31:2], 2'b00}. `next_pc` becomes that value + 4.
- Otherwise, `imem_en_o` = !`stall_i` || (!`hold`.valid && !`inflight`), and `imem_addr_o` = `next_pc`. `next_pc` advances by 4 on each issue.

IF/ID update at each edge, in priority order:
1. `redirect_i` high:
   - `if_id_valid_o` is cleared.
   - `hold` is cleared.
   - The current in-flight response is discarded.
   - Redirect overrides `stall_i`.
2. `stall_i` high:
   - IF/ID holds.
   - A live in-flight response is written into `hold`, and the state moves to PARKED.
3. `stall_i` low and `hold` valid:
   - IF/ID loads `hold`, and `hold` is cleared.
   - A request issues in the same cycle, so no bubble is introduced.
4. `stall_i` low and an in-flight response is live: IF/ID loads {in-flight PC, `imem_rdata_i`} with valid = 1.
5. Otherwise: `if_id_valid_o` is cleared (bubble). `if_id_instr_o` is set to `NOP_INSTR`.

Invariants and boundary conditions:
- `hold` and a live in-flight response never coexist.
- The skid buffer cannot overflow.
- A fetch from 32'hFFFF_FFFC wraps `next_pc` to 32'h0000_0000.
- A redirect while in PARKED drops the parked entry.

## Timing
- Reset values:
  - `if_id_valid_o` = 0, `if_id_pc_o` = 0, `if_id_pc4_o` = 4, `if_id_instr_o` = `NOP_INSTR`.
  - `next_pc` = `RESET_PC`; `inflight` and `hold` are empty.
- `imem_en_o` and `imem_addr_o` are combinational from state and inputs. During reset they read 0 and `RESET_PC`.
- First edge after `rst_n` rises: request `RESET_PC` is issued. `if_id_valid_o` = 1 with PC = `RESET_PC` one edge later.
- Fetch-to-IF/ID latency is 2 edges from issue. Steady-state throughput is one instruction per cycle.
- Redirect penalty: the target appears in IF/ID 2 edges after the `redirect_i` cycle, with one bubble in between.
- Reset asserted mid-operation clears all state immediately, independent of `clk`.

## Structure
- A shared processor package holds:
  - the `NOP_INSTR` default;
  - the word-size constant (4);
  - a struct type for an IF/ID entry {valid, pc, instr}, which is reused by `hold` and the IF/ID register.
- One natural sub-module is `fetch_skid_buffer`, the one-entry hold register with load, drain and flush.

## Test plan
- Reset release with `RESET_PC` = 0 and memory word at address 4n = n: `imem_addr_o` sequence is 0, 4, 8, … Starting one edge later, IF/ID shows PC 0, 4, 8 with instr 0, 1, 2, valid every cycle.
- 3-cycle `stall_i` pulse while PC 8 is in IF/ID and 12 is in flight: IF/ID holds PC 8, 12 is parked, and `imem_en_o` = 0. After release, IF/ID shows 12 then 16 back-to-back, with no duplicate and no gap.
- `redirect_i` with `redirect_pc_i` = 32'h0000_0103 during a stall: `imem_addr_o` = 32'h100 in that cycle. The next IF/ID is invalid, then PC 32'h100.
- Redirect while in PARKED (stall still high): the parked entry is discarded. IF/ID shows the redirect target and never the parked PC.
- `next_pc` = 32'hFFFF_FFFC: the following request address is 0, and `if_id_pc4_o` = 0 when FFFF_FFFC reaches IF/ID.
- `rst_n` low while PARKED: the outputs take their reset values immediately. Fetch restarts at `RESET_PC`.
